// File: rtl/click_sync_sink.sv
// rtl/click_sync_sink.sv - clocked sink for a 2-phase click pipeline
// Synchronizes the request phase, buffers bundled data in a FIFO, returns the ack.
module click_sync_sink #(
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_req,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          in_ack,
  output logic                          out_valid,
  output logic [DATA_W-1:0]             out_data,
  input  logic                          out_ready,
  output logic                          accept,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_ack;
  logic                   r_accept;
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [CNT_W-1:0]       r_count;
  logic [DATA_W-1:0]      r_mem [FIFO_DEPTH];

  logic w_req_s;
  logic w_pending;
  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_req_s   = r_sync[SYNC_STAGES-1];
  assign w_pending = (w_req_s != r_ack);
  // Full is judged on start-of-cycle occupancy, so a same-cycle pop never frees a slot early.
  assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_push    = w_pending && !w_full;
  assign w_pop     = out_valid && out_ready;

  assign in_ack    = r_ack;
  assign accept    = r_accept;
  assign count     = r_count;
  assign out_valid = (r_count != '0);
  assign out_data  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync   <= '0;
      r_ack    <= 1'b0;
      r_accept <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], in_req};
      r_accept <= w_push;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        r_ack    <= ~r_ack;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; in_data is bundled and therefore stable while pending.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

endmodule

// File: tb/tb_click_sync_sink.sv
// tb/tb_click_sync_sink.sv - self-checking bench for click_sync_sink
// Per-cycle reference model plus table vectors and directed corner sequences.
module tb_click_sync_sink;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int SYNC   = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_req = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ack;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready = 1'b0;
  logic              accept;
  logic [2:0]        count;

  click_sync_sink #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .in_req(in_req), .in_data(in_data), .in_ack(in_ack),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .accept(accept), .count(count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference: token queue, ack phase, and a delay line of sampled requests.
  int m_q[$];
  bit m_hist[$];
  bit m_ack;
  bit m_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_hist.delete();
    for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
    m_ack = 1'b0;
    m_acc = 1'b0;
  endtask

  task automatic tick();
    bit c_rst, c_req, c_ready, seen_req, push;
    int c_data;
    c_rst = rst; c_req = in_req; c_ready = out_ready; c_data = int'(in_data);
    @(posedge clk);
    if (c_rst) begin
      model_reset();
    end else begin
      seen_req = m_hist[0];
      push = (seen_req != m_ack) && (m_q.size() < DEPTH);
      if (c_ready && m_q.size() > 0) void'(m_q.pop_front());
      if (push) begin
        m_q.push_back(c_data);
        m_ack = ~m_ack;
      end
      m_acc = push;
      m_hist.push_back(c_req);
      void'(m_hist.pop_front());
    end
    #1;
    chk("m_ack",   in_ack,    m_ack);
    chk("m_valid", out_valid, m_q.size() > 0);
    chk("m_count", count,     m_q.size());
    chk("m_accept", accept,   m_acc);
    if (m_q.size() > 0) chk("m_data", out_data, m_q[0]);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_req = 1'b0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Waits for the previous handshake to close, then launches one 2-phase token.
  task automatic send_token(input logic [7:0] d);
    int n = 0;
    while (in_ack !== in_req && n < 40) begin
      tick();
      n++;
    end
    if (in_ack !== in_req) chk("send_timeout", in_ack, in_req);
    in_data = d;
    in_req = ~in_req;
  endtask

  typedef struct {
    bit         rst;
    bit         req;
    logic [7:0] data;
    bit         ready;
    bit         e_ack;
    bit         e_valid;
    int         e_count;
    bit         e_acc;
    logic [7:0] e_data;
  } vec_t;

  vec_t tbl[9];
  int   acc_n;

  initial begin
    model_reset();

    tbl[0] = '{1, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00};
    tbl[1] = '{0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00};
    tbl[2] = '{0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00};
    tbl[3] = '{0, 1, 8'h5A, 0, 0, 0, 0, 0, 8'h00};
    tbl[4] = '{0, 1, 8'h5A, 0, 0, 0, 0, 0, 8'h00};
    tbl[5] = '{0, 1, 8'h5A, 0, 1, 1, 1, 1, 8'h5A};
    tbl[6] = '{0, 1, 8'h5A, 0, 1, 1, 1, 0, 8'h5A};
    tbl[7] = '{0, 1, 8'h5A, 1, 1, 0, 0, 0, 8'h00};
    tbl[8] = '{0, 1, 8'h5A, 0, 1, 0, 0, 0, 8'h00};

    for (int i = 0; i < 9; i++) begin
      rst = tbl[i].rst; in_req = tbl[i].req; in_data = tbl[i].data; out_ready = tbl[i].ready;
      tick();
      chk($sformatf("tbl%0d_ack", i),   in_ack,    tbl[i].e_ack);
      chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].e_valid);
      chk($sformatf("tbl%0d_count", i), count,     tbl[i].e_count);
      chk($sformatf("tbl%0d_acc", i),   accept,    tbl[i].e_acc);
      if (tbl[i].e_valid) chk($sformatf("tbl%0d_data", i), out_data, tbl[i].e_data);
    end

    // Fill beyond depth, then full+pop in the same cycle.
    do_reset();
    for (int k = 1; k <= 5; k++) send_token(8'(k));
    repeat (6) tick();
    chk("fill_count", count, 4);
    chk("fill_ack_held", in_ack, 1'b0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("fullpop_count", count, 3);
    chk("fullpop_noacc", accept, 1'b0);
    tick();
    chk("fullpop_count_next", count, 4);
    chk("fullpop_acc_next", accept, 1'b1);
    chk("fifth_ack", in_ack, 1'b1);
    out_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      chk($sformatf("order_valid%0d", k), out_valid, 1'b1);
      chk($sformatf("order_data%0d", k), out_data, k);
      tick();
    end
    chk("drained", out_valid, 1'b0);
    out_ready = 1'b0;

    // Simultaneous push and pop at count 2.
    do_reset();
    send_token(8'hB1);
    send_token(8'hB2);
    repeat (5) tick();
    chk("pp_pre_count", count, 2);
    send_token(8'hA3);
    tick();
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("pp_count", count, 2);
    chk("pp_acc", accept, 1'b1);
    chk("pp_head", out_data, 8'hB2);

    // Reset mid-handshake, released with in_req held high.
    do_reset();
    send_token(8'h11);
    send_token(8'h22);
    send_token(8'h33);
    repeat (5) tick();
    chk("rst_pre_count", count, 3);
    send_token(8'h44);
    tick();
    rst = 1'b1; in_req = 1'b1;
    tick();
    chk("rst_ack", in_ack, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_acc", accept, 1'b0);
    rst = 1'b0;
    acc_n = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (accept) acc_n++;
    end
    chk("rel_accepts", acc_n, 1);
    chk("rel_ack", in_ack, 1'b1);
    chk("rel_count", count, 1);
    chk("rel_data", out_data, 8'h44);

    // Randomized traffic, exercises pointer wrap well past 20 tokens.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (in_ack === in_req && $urandom_range(0, 1) == 1) begin
        in_data = 8'($urandom);
        in_req = ~in_req;
      end
      tick();
    end
    out_ready = 1'b1;
    repeat (12) tick();
    chk("rand_drained", count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
